// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame shifted out
// on device clock falling edges, then the device acknowledge bit is checked.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 1200,
    parameter int unsigned REQ_CYCLES     = 24,
    parameter int unsigned START_TIMEOUT  = 180000,
    parameter int unsigned XFER_TIMEOUT   = 24000
) (
    input  logic       clk,
    input  logic       rst_n,
    inout  logic       ps2_clk,
    inout  logic       ps2_data,
    input  logic       write,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned MAX_AB  = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int unsigned MAX_CD  = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int unsigned MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] REQ_LAST  = CW'(REQ_CYCLES - 1);
    localparam logic [CW-1:0] START_END = CW'(START_TIMEOUT);
    localparam logic [CW-1:0] XFER_END  = CW'(XFER_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQUEST,
        S_WAIT_START,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_FINISH
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [8:0]    shreg, shreg_n;
    logic          clk_oe, clk_oe_n;
    logic          data_oe, data_oe_n;
    logic          err, err_n;

    logic          clk_s1, clk_s2, clk_prev;
    logic          data_s1, data_s2;
    logic          fall;

    // Open-drain: the pins are only ever pulled low or released.
    assign ps2_clk  = clk_oe  ? 1'b0 : 1'bz;
    assign ps2_data = data_oe ? 1'b0 : 1'bz;

    assign fall  = clk_prev & ~clk_s2;
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_FINISH);
    assign error = done & err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            clk_oe  <= clk_oe_n;
            data_oe <= data_oe_n;
            err     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        clk_oe_n  = clk_oe;
        data_oe_n = data_oe;
        err_n     = err;

        case (state)
            S_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (write) begin
                    shreg_n   = {~^tx_data, tx_data};
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    err_n     = 1'b0;
                    clk_oe_n  = 1'b1;
                    state_n   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (cnt == INH_LAST) begin
                    cnt_n     = '0;
                    data_oe_n = 1'b1;
                    state_n   = S_REQUEST;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            S_REQUEST: begin
                if (cnt == REQ_LAST) begin
                    cnt_n    = '0;
                    clk_oe_n = 1'b0;
                    state_n  = S_WAIT_START;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            // Shift register fills with 1s so the edge after parity releases data (stop bit).
            S_WAIT_START: begin
                if (fall) begin
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    data_oe_n = ~shreg[0];
                    shreg_n   = {1'b1, shreg[8:1]};
                    state_n   = S_SHIFT;
                end else if (cnt == START_END) begin
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b0;
                    err_n     = 1'b1;
                    state_n   = S_FINISH;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            S_SHIFT: begin
                if (fall) begin
                    cnt_n     = '0;
                    data_oe_n = ~shreg[0];
                    shreg_n   = {1'b1, shreg[8:1]};
                    if (bit_cnt == 4'd8) begin
                        state_n = S_ACK;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end else if (cnt == XFER_END) begin
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b0;
                    err_n     = 1'b1;
                    state_n   = S_FINISH;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            S_ACK: begin
                if (fall) begin
                    cnt_n = '0;
                    if (data_s2) begin
                        clk_oe_n  = 1'b0;
                        data_oe_n = 1'b0;
                        err_n     = 1'b1;
                        state_n   = S_FINISH;
                    end else begin
                        state_n = S_WAIT_IDLE;
                    end
                end else if (cnt == XFER_END) begin
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b0;
                    err_n     = 1'b1;
                    state_n   = S_FINISH;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            S_WAIT_IDLE: begin
                if (clk_s2 && data_s2) begin
                    state_n = S_FINISH;
                end else if (cnt == XFER_END) begin
                    err_n   = 1'b1;
                    state_n = S_FINISH;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            S_FINISH: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                cnt_n     = '0;
                bit_cnt_n = '0;
                state_n   = S_IDLE;
            end

            default: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                state_n   = S_IDLE;
            end
        endcase
    end

endmodule
